// File: rtl/imm_gen_pkg.sv
// Purpose: shared opcode constants, format codes and small decode helpers for imm_gen_pipe.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imm_gen_pkg;

  // Major opcodes, inst[6:0]
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;

  // Format code reported alongside the immediate
  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_NONE  = 3'd7
  } fmt_t;

  // funct3 values 001 (SLL*) and 101 (SRL*/SRA*) carry a shift amount, not an I-immediate
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Purpose: combinational RV32/RV64 immediate decoder (imm, format code, illegal flag).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller registers the result.
// Ports: inst (32b instruction) -> imm (XLEN, sign/zero extended), fmt (fmt_t), illegal (unknown opcode).
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit RV64 = (XLEN == 64)
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            illegal
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  // Every immediate fits a signed 32-bit value; widening to XLEN is one sign extension.
  // Shift amounts are built with a zero top bit so the same extension zero-fills them.
  logic signed [31:0] imm32;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_OPIMM: begin
        if (is_shift(funct3)) begin
          // funct7 (inst[31:26]/[31:25]) must not leak into the shift amount
          fmt   = FMT_SHAMT;
          imm32 = RV64 ? {26'd0, inst[25:20]} : {27'd0, inst[24:20]};
        end else begin
          fmt   = FMT_I;
          imm32 = {{20{inst[31]}}, inst[31:20]};
        end
      end
      OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE: begin
        fmt   = FMT_I;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_OPIMM32: begin
        if (!RV64) begin
          illegal = 1'b1;
        end else if (is_shift(funct3)) begin
          // word shifts only ever use a 5-bit amount
          fmt   = FMT_SHAMT;
          imm32 = {27'd0, inst[24:20]};
        end else begin
          fmt   = FMT_I;
          imm32 = {{20{inst[31]}}, inst[31:20]};
        end
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {inst[31:12], 12'd0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_OP: begin
        fmt = FMT_R;
      end
      OPC_OP32: begin
        if (RV64) fmt = FMT_R;
        else      illegal = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // signed source: the size cast replicates imm32[31] up to XLEN
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Purpose: registered immediate generator; decodes in front of a 2-entry output buffer.
// Latency: 1 cycle from accepted instruction to out_valid.
// Backpressure: in_ready = buffer not full (registered count); flush drops everything, including that cycle's input.
// Ports: clk, rst_n (sync, active low), flush; in_valid/in_ready/in_inst; out_valid/out_ready with
//        out_imm (XLEN), out_fmt (3b), out_illegal, out_inst (32b passthrough).
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit RV64 = (XLEN == 64)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [31:0]     out_inst
);

  logic [XLEN-1:0] dec_imm;
  fmt_t            dec_fmt;
  logic            dec_illegal;

  imm_decode #(
    .XLEN (XLEN),
    .RV64 (RV64)
  ) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Entries hold decoded results so out_* are driven from flops, not from the decoder
  logic [XLEN-1:0] imm_q  [2];
  fmt_t            fmt_q  [2];
  logic            ill_q  [2];
  logic [31:0]     inst_q [2];

  logic       head;
  logic       tail;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // No path from out_ready: a pop at count=2 only frees a slot on the following cycle.
  // During flush the buffer is emptied anyway, so the offer is taken and discarded.
  assign in_ready  = rst_n && (flush || (count != 2'd2));
  assign out_valid = (count != 2'd0);

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        imm_q[i]  <= '0;
        fmt_q[i]  <= FMT_NONE;
        ill_q[i]  <= 1'b0;
        inst_q[i] <= '0;
      end
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        imm_q[tail]  <= dec_imm;
        fmt_q[tail]  <= dec_fmt;
        ill_q[tail]  <= dec_illegal;
        inst_q[tail] <= in_inst;
        tail         <= ~tail;
      end
      // at count=1 a simultaneous push lands in the slot head is advancing to
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_imm     = imm_q[head];
  assign out_fmt     = fmt_q[head];
  assign out_illegal = ill_q[head];
  assign out_inst    = inst_q[head];

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, handshaked RV32/RV64 immediate generator for the decode stage, successor to the combinational immediate generator.
- Accepts one instruction word per cycle on a valid/ready input and decodes every base format (I, S, B, U, J, shift-immediate, R).
- Emits a sign-extended XLEN immediate, a format code and an illegal flag through a 2-entry output buffer, so fetch can stall without losing data.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- RV64, (XLEN==64), enables OP-IMM-32 decode and the 6-bit shamt.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous clear of buffered entries.
- in_valid  in  1  input instruction present.
- in_ready  out  1  block can accept an instruction this cycle.
- in_inst  in  32  instruction word.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_imm  out  XLEN  immediate, sign- or zero-extended.
- out_fmt  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT, 7=NONE.
- out_illegal  out  1  opcode not recognised.
- out_inst  out  32  instruction word passthrough.

Behaviour:
- Reset is synchronous, taking effect at a clk edge with rst_n low. After reset:
  - count=0, out_valid=0, out_imm=0, out_fmt=7, out_illegal=0, out_inst=0.
  - in_ready=0 while rst_n is low, and 1 in the first cycle after release.
- Handshake:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count != 2); it depends only on registered state, with no combinational path from out_ready.
  - out_valid = (count != 0).
- Latency: an instruction pushed at edge N appears on out_* after edge N, i.e. 1 cycle.
- Buffer: 2 entries, head/tail pointers with 1-bit wrap. Entries are decoded before storage, so out_* come straight from registers.
- Simultaneous events:
  - Push and pop in the same cycle at count=1: count stays 1 and the new entry becomes the head.
  - At count=2, in_ready=0, so there is no push; a pop reduces count to 1.
  - At count=0, no pop is possible.
- flush has priority over push and pop. Next cycle count=0 and out_valid=0, and any instruction offered that cycle is dropped. in_ready stays 1 during flush.
- A reset asserted mid-operation discards all entries, identical to the post-reset state.
- Decode, keyed by opcode = inst[6:0]:
  - 0010011 OP-IMM:
    - funct3 001/101 -> SHAMT. The immediate is zero-extended inst[24:20] when XLEN=32, or inst[25:20] when RV64. funct7 is ignored.
    - Any other funct3 -> I, sext(inst[31:20]).
  - 0000011 LOAD, 1100111 JALR, 1110011 SYSTEM -> I.
  - 0011011 OP-IMM-32 (RV64 only) -> I, or SHAMT using inst[24:20] for funct3 001/101. When XLEN=32 it is illegal.
  - 0100011 -> S: sext({inst[31:25],inst[11:7]}).
  - 1100011 -> B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 0110111, 0010111 -> U: sext({inst[31:12],12'b0}). Upper bits replicate inst[31] when XLEN=64.
  - 1101111 -> J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - 0110011, 0111011 (RV64) -> R, imm=0.
  - 0001111 FENCE -> I.
  - Anything else -> fmt=7, imm=0, illegal=1.
- Sign extension always replicates the format's top immediate bit to XLEN.

Decomposition:
- Package imm_gen_pkg holds:
  - opcode localparams: OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM, OPC_OP, OPC_OPIMM32, OPC_OP32, OPC_FENCE;
  - fmt codes FMT_R…FMT_NONE.
- One combinational sub-module, imm_decode (inputs inst; outputs imm, fmt, illegal; parameter XLEN), instantiated in front of the 2-entry buffer.

Test Plan:
- XLEN=32, in_inst=0x00250513 (addi) -> one cycle later out_valid=1, out_imm=0x00000002, out_fmt=1, out_illegal=0.
- in_inst=0x41F5D593 (srai 31) -> out_imm=0x0000001F, out_fmt=6 (the funct7 bit must not leak into the immediate).
- Back-to-back with out_ready=1:
  - 0xFE512E23 (sw -4) -> 0xFFFFFFFC, fmt 2.
  - 0xFE000CE3 (beq -8) -> 0xFFFFFFF8, fmt 3.
  - 0x123450B7 (lui) -> 0x12345000, fmt 4.
  - 0x001000EF (jal +2048) -> 0x00000800, fmt 5.
  - Expected: one result per cycle, in order.
- Backpressure:
  - Hold out_ready=0 and push 3 instructions. in_ready drops to 0 after the 2nd push, and the 3rd is held until a pop.
  - Release out_ready: entries drain in order, and simultaneous push/pop at count=1 keeps count at 1.
- Flush with count=2 plus an instruction offered in the same cycle -> next cycle out_valid=0, and the dropped instruction never appears. Reset asserted mid-stream -> out_valid=0, out_fmt=7.
- XLEN=64:
  - 0x800000B7 (lui) -> 0xFFFFFFFF80000000.
  - slli with shamt 63 (0x03F59593) -> 0x3F.
  - in_inst=0x0000007F -> out_illegal=1, out_imm=0, fmt 7.
